aib_adaptrxdp_wa_gearbox: RTL and testbench
===========================================

Name: aib_adaptrxdp_wa_gearbox

Overview:
- Single-clock receive-side word-alignment and gearbox for the adapter RX datapath.
- Finds the marker bit, locks group phase with hysteresis, and packs N consecutive DWIDTH words (N = 1, 2, 4 or 8) into one wide word before the async FIFO write port.
- Successor to the sticky, fixed-pattern alignment logic: it adds a configurable ratio up to MAXR, a lock/unlock state machine, phase slipping and a programmable marker position.

Parameters:
- DWIDTH, 80: input word width.
- MAXR, 4: maximum pack ratio; power of 2, legal values 1..8.
- LOCK_CNT, 3: consecutive good marker groups required to declare lock.
- UNLOCK_CNT, 4: consecutive bad groups in LOCKED required to drop lock.
- MKW, $clog2(DWIDTH): width of the marker index.

Ports:
- wr_clk  in  1  sole clock.
- wr_rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  input word valid.
- wr_data  in  DWIDTH  input word.
- r_ratio  in  2  pack ratio select: 0=1x, 1=2x, 2=4x, 3=8x; N = 1<<r_ratio, must be <= MAXR.
- r_wa_en  in  1  word-alignment enable.
- r_mkbit  in  MKW  marker bit index into wr_data.
- out_data  out  DWIDTH*MAXR  packed word; word k sits in slice k; slices at index >= N are zero.
- out_valid  out  1  one-cycle strobe: out_data complete.
- wa_lock  out  1  alignment locked.
- wa_state  out  2  FSM state, for debug.

Behaviour:
- Reset:
  - out_data=0, out_valid=0, wa_lock=0.
  - State HUNT (0), phase=0, good_cnt=0, bad_cnt=0.
- Marker definition:
  - mk = wr_data[r_mkbit], sampled only when wr_en=1.
  - A group is good when mk=1 on phase N-1 and mk=0 on phases 0..N-2.
- Phase counter:
  - Increments modulo N on each wr_en.
  - Holds when wr_en=0; gaps do not break a group.
- Packing:
  - A word with wr_en=1 at phase p is written into slice p of the pack register.
  - On phase N-1: out_data <= the pack register with the current word merged, and out_valid=1 on the next cycle. Latency is 1 cycle from the last word.
  - Slices at index >= N are forced to 0.
  - out_data holds between strobes.
- FSM states: HUNT=0, VERIFY=1, LOCKED=2.
  - HUNT: on wr_en with mk=1, force phase so the next word is phase 0 (slip). That word closes a group and out_valid fires. Go to VERIFY with good_cnt=1.
  - VERIFY:
    - A bad group returns to HUNT immediately, at the first offending word.
    - A good group increments good_cnt.
    - good_cnt==LOCK_CNT leads to LOCKED, with wa_lock=1 on the same edge.
  - LOCKED:
    - A bad group increments bad_cnt; a good group clears it.
    - bad_cnt==UNLOCK_CNT leads to HUNT: wa_lock=0, counters cleared. Phase is not reset; HUNT re-slips on the next marker.
    - The phase counter never slips while LOCKED.
- 1x mode (N=1):
  - Marker check is skipped; every word is a group.
  - With r_wa_en=1, the FSM goes HUNT->LOCKED on the first wr_en.
- r_wa_en=0:
  - FSM held in HUNT, counters cleared, wa_lock=0.
  - Phase free-runs from 0 and packing continues, so output is unaligned.
- Configuration change:
  - r_ratio, r_wa_en and r_mkbit are registered internally.
  - Any change forces HUNT, phase=0, counters=0, wa_lock=0 and discards the partial pack on the following cycle.
  - No out_valid is issued for the aborted group.
- r_ratio selecting N>MAXR: treated as N=MAXR.
- Counters saturate; they never wrap.
- Reset asserted mid-group: all state returns to reset values immediately, with no partial output.

Optional Feature:
- Macro AIB_WA_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt [7:0]: saturating count of bad groups seen in LOCKED plus lock-loss events.
  - Cleared by reset and by any configuration change.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package aib_adaptrxdp_pkg holds:
  - FSM state typedef {HUNT, VERIFY, LOCKED}.
  - Ratio encodings FIFO_1X/2X/4X/8X.
  - Default LOCK_CNT and UNLOCK_CNT constants.
- One sub-module, aib_adaptrxdp_wa_fsm: phase counter, marker check, lock FSM; outputs phase and wa_lock.
- The top level holds the pack register and the config-change detect.

Test Plan:
- 4x, mk=bit 79, marker on every 4th word, 20 contiguous words: wa_lock rises on the 12th word (3 good groups); out_valid every 4 words, 1 cycle after the marker word; slices 0..3 hold words in order.
- 4x, stream starts 2 words off-phase: HUNT slips on the first marker; the next 4 words pack aligned; no misordered out_data after the slip.
- Locked 4x, inject 3 bad groups then 1 good group then 4 bad groups: wa_lock stays 1 through the first 3 bad (bad_cnt cleared by the good group); wa_lock drops on the 4th consecutive bad group; state returns to HUNT.
- 2x with wr_en gapped 1-of-3 cycles, marker on odd words: lock after 6 words; gaps cause no errors; out_data[DWIDTH*4-1:DWIDTH*2]=0.
- Locked 4x, change r_ratio to 2x mid-group: next cycle wa_lock=0, phase=0, no out_valid for the partial group; re-lock after 3 good 2x groups.
- With AIB_WA_ERRCNT_EN: 300 bad groups while locked saturate err_cnt at 255; reset clears it to 0.

Source files
------------

// File: rtl/aib_adaptrxdp_pkg.sv
// Shared types and constants for the adapter RX datapath word-alignment gearbox.
package aib_adaptrxdp_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } wa_state_e;

    localparam logic [1:0] FIFO_1X = 2'd0;
    localparam logic [1:0] FIFO_2X = 2'd1;
    localparam logic [1:0] FIFO_4X = 2'd2;
    localparam logic [1:0] FIFO_8X = 2'd3;

    localparam int WA_LOCK_CNT   = 3;
    localparam int WA_UNLOCK_CNT = 4;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/aib_adaptrxdp_wa_fsm.sv
// Phase counter, marker check and lock/unlock FSM for the RX word aligner.
// Optional error counter enabled by macro AIB_WA_ERRCNT_EN.
module aib_adaptrxdp_wa_fsm
    import aib_adaptrxdp_pkg::*;
#(
    parameter int LOCK_CNT   = WA_LOCK_CNT,
    parameter int UNLOCK_CNT = WA_UNLOCK_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic       mk,
    input  logic       wa_en,
    input  logic [1:0] ratio,
    output logic [2:0] word_phase,
    output logic       group_end,
    output logic       wa_lock,
    output wa_state_e  state
`ifdef AIB_WA_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [7:0] LOCK_TH   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_CNT);

    wa_state_e  state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] good_q, good_d;
    logic [7:0] bad_q, bad_d;
    logic       grp_bad_q, grp_bad_d;
    logic [2:0] last_ph;
    logic       slip, word_bad, bad_grp, lock_loss;

    assign last_ph = 3'((4'd1 << ratio) - 4'd1);

    // A marker seen while hunting is treated as the last word of a group.
    always_comb begin
        slip       = wa_en && (state_q == HUNT) && mk && (ratio != FIFO_1X);
        word_phase = slip ? last_ph : phase_q;
        group_end  = wr_en && !clr && (word_phase == last_ph);
        word_bad   = (ratio != FIFO_1X) && ((word_phase == last_ph) ? !mk : mk);
    end

    assign bad_grp   = group_end && wa_en && (state_q == LOCKED) && (grp_bad_q || word_bad);
    assign lock_loss = bad_grp && (sat_inc(bad_q, 2'd1) >= UNLOCK_TH);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        good_d    = good_q;
        bad_d     = bad_q;
        grp_bad_d = grp_bad_q;
        if (clr) begin
            state_d   = HUNT;
            phase_d   = '0;
            good_d    = '0;
            bad_d     = '0;
            grp_bad_d = 1'b0;
        end else if (wr_en) begin
            phase_d = group_end ? 3'd0 : phase_q + 3'd1;
            if (!wa_en) begin
                state_d   = HUNT;
                good_d    = '0;
                bad_d     = '0;
                grp_bad_d = 1'b0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        if (ratio == FIFO_1X) begin
                            state_d = LOCKED;
                        end else if (mk) begin
                            good_d  = 8'd1;
                            state_d = (8'd1 >= LOCK_TH) ? LOCKED : VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (word_bad) begin
                            state_d = HUNT;
                            good_d  = '0;
                        end else if (group_end) begin
                            good_d = sat_inc(good_q, 2'd1);
                            if (good_d >= LOCK_TH) state_d = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (group_end) begin
                            grp_bad_d = 1'b0;
                            bad_d     = bad_grp ? sat_inc(bad_q, 2'd1) : 8'd0;
                            if (lock_loss) begin
                                state_d = HUNT;
                                good_d  = '0;
                                bad_d   = '0;
                            end
                        end else begin
                            grp_bad_d = grp_bad_q || word_bad;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            phase_q   <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            grp_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            grp_bad_q <= grp_bad_d;
        end
    end

    assign wa_lock = (state_q == LOCKED);
    assign state   = state_q;

`ifdef AIB_WA_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // A lock-loss group counts both as a bad group and as a lock-loss event.
    always_comb begin
        err_d = clr ? 8'd0 : sat_inc(err_q, {lock_loss, bad_grp && !lock_loss});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: rtl/aib_adaptrxdp_wa_gearbox.sv
// RX word-alignment gearbox: packs N aligned DWIDTH words into one wide word.
// Optional err_cnt output enabled by macro AIB_WA_ERRCNT_EN.
module aib_adaptrxdp_wa_gearbox
    import aib_adaptrxdp_pkg::*;
#(
    parameter int DWIDTH     = 80,
    parameter int MAXR       = 4,
    parameter int LOCK_CNT   = WA_LOCK_CNT,
    parameter int UNLOCK_CNT = WA_UNLOCK_CNT,
    parameter int MKW        = $clog2(DWIDTH)
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst_n,
    input  logic                   wr_en,
    input  logic [DWIDTH-1:0]      wr_data,
    input  logic [1:0]             r_ratio,
    input  logic                   r_wa_en,
    input  logic [MKW-1:0]         r_mkbit,
    output logic [DWIDTH*MAXR-1:0] out_data,
    output logic                   out_valid,
    output logic                   wa_lock,
    output logic [1:0]             wa_state
`ifdef AIB_WA_ERRCNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    localparam logic [1:0] MAX_RATIO = (MAXR >= 8) ? FIFO_8X :
                                       (MAXR >= 4) ? FIFO_4X :
                                       (MAXR >= 2) ? FIFO_2X : FIFO_1X;

    logic [1:0]     ratio_q, ratio_d, ratio_eff;
    logic           wa_en_q, wa_en_d;
    logic [MKW-1:0] mkbit_q, mkbit_d;
    logic           cfg_chg, mk, group_end;
    logic [2:0]     word_phase, last_ph;
    wa_state_e      fsm_state;

    logic [MAXR-1:0][DWIDTH-1:0] pack_q, pack_d, merged;
    logic [MAXR-1:0][DWIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;

    assign cfg_chg   = (r_ratio != ratio_q) || (r_wa_en != wa_en_q) || (r_mkbit != mkbit_q);
    assign ratio_eff = (ratio_q > MAX_RATIO) ? MAX_RATIO : ratio_q;
    assign last_ph   = 3'((4'd1 << ratio_eff) - 4'd1);

    // Marker indices beyond the word width read as zero.
    always_comb begin
        mk = 1'b0;
        for (int i = 0; i < DWIDTH; i++) begin
            if (MKW'(i) == mkbit_q) mk = wr_data[i];
        end
    end

    aib_adaptrxdp_wa_fsm #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_fsm (
        .clk        (wr_clk),
        .rst_n      (wr_rst_n),
        .clr        (cfg_chg),
        .wr_en      (wr_en),
        .mk         (mk),
        .wa_en      (wa_en_q),
        .ratio      (ratio_eff),
        .word_phase (word_phase),
        .group_end  (group_end),
        .wa_lock    (wa_lock),
        .state      (fsm_state)
`ifdef AIB_WA_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    // A config change drops the partial pack and the word presented with it.
    always_comb begin
        ratio_d     = r_ratio;
        wa_en_d     = r_wa_en;
        mkbit_d     = r_mkbit;
        merged      = pack_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        for (int k = 0; k < MAXR; k++) begin
            if (3'(k) == word_phase) merged[k] = wr_data;
            if (3'(k) > last_ph)     merged[k] = '0;
        end
        if (cfg_chg) begin
            pack_d = '0;
        end else if (wr_en) begin
            if (group_end) begin
                out_data_d  = merged;
                out_valid_d = 1'b1;
                pack_d      = '0;
            end else begin
                pack_d = merged;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            ratio_q     <= '0;
            wa_en_q     <= 1'b0;
            mkbit_q     <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ratio_q     <= ratio_d;
            wa_en_q     <= wa_en_d;
            mkbit_q     <= mkbit_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign wa_state  = fsm_state;

endmodule

// File: tb/tb_aib_adaptrxdp_wa_gearbox.sv
// Randomized scoreboard bench for aib_adaptrxdp_wa_gearbox with a group-level reference model.
// Also checks err_cnt when built with AIB_WA_ERRCNT_EN.
module tb_aib_adaptrxdp_wa_gearbox;

    localparam int DW     = 80;
    localparam int MAXR   = 4;
    localparam int LOCK   = 3;
    localparam int UNLOCK = 4;
    localparam int MKW    = 7;
    localparam int OW     = DW * MAXR;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [DW-1:0]  wr_data;
    logic [1:0]     r_ratio;
    logic           r_wa_en;
    logic [MKW-1:0] r_mkbit;
    logic [OW-1:0]  out_data;
    logic           out_valid, wa_lock;
    logic [1:0]     wa_state;
`ifdef AIB_WA_ERRCNT_EN
    logic [7:0]     err_cnt;
`endif

    always #5 clk = ~clk;

    aib_adaptrxdp_wa_gearbox #(
        .DWIDTH(DW), .MAXR(MAXR), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK), .MKW(MKW)
    ) dut (
        .wr_clk    (clk),
        .wr_rst_n  (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .r_ratio   (r_ratio),
        .r_wa_en   (r_wa_en),
        .r_mkbit   (r_mkbit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .wa_lock   (wa_lock),
        .wa_state  (wa_state)
`ifdef AIB_WA_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the open group is a queue of words, the lock level is a small integer.
    logic [1:0]     m_ratio;
    logic           m_wa_en;
    logic [MKW-1:0] m_mkbit;
    logic [DW-1:0]  grp[$];
    int             m_st, m_good, m_bad, m_err;
    bit             m_grp_bad;
    logic [OW-1:0]  exp_q[$];

    logic [1:0]     cur_ratio;
    logic           cur_wa;
    logic [MKW-1:0] cur_mk;

    task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nOf(input logic [1:0] r);
        int n = 1 << r;
        return (n > MAXR) ? MAXR : n;
    endfunction

    function automatic void modelClear();
        grp.delete();
        m_st = 0; m_good = 0; m_bad = 0; m_grp_bad = 0; m_err = 0;
    endfunction

    function automatic void modelWord(input logic [DW-1:0] d);
        int n = nOf(m_ratio);
        bit mk = d[m_mkbit];
        bit slip = m_wa_en && (m_st == 0) && mk && (n > 1);
        bit closes = slip || (grp.size() + 1 == n);
        bit bad = (n > 1) && (closes ? !mk : mk);
        int pos = slip ? n - 1 : grp.size();
        logic [OW-1:0] o;
        if (closes) begin
            o = '0;
            foreach (grp[i]) o[i*DW +: DW] = grp[i];
            o[pos*DW +: DW] = d;
            exp_q.push_back(o);
            grp.delete();
        end else begin
            grp.push_back(d);
        end
        if (!m_wa_en) begin
            m_st = 0; m_good = 0; m_bad = 0; m_grp_bad = 0;
        end else if (m_st == 0) begin
            if (n == 1) m_st = 2;
            else if (mk) begin m_good = 1; m_st = (LOCK <= 1) ? 2 : 1; end
        end else if (m_st == 1) begin
            if (bad) begin m_st = 0; m_good = 0; end
            else if (closes) begin m_good++; if (m_good >= LOCK) m_st = 2; end
        end else begin
            m_grp_bad = m_grp_bad || bad;
            if (closes) begin
                if (m_grp_bad) begin
                    m_bad++; m_err++;
                    if (m_bad >= UNLOCK) begin m_st = 0; m_good = 0; m_bad = 0; m_err++; end
                end else m_bad = 0;
                m_grp_bad = 0;
            end
        end
        if (m_err > 255) m_err = 255;
    endfunction

    task automatic applyStimulus(input bit we, input logic [DW-1:0] d, input logic [1:0] ratio,
                                 input bit wa, input logic [MKW-1:0] mkb);
        wr_en = we; wr_data = d; r_ratio = ratio; r_wa_en = wa; r_mkbit = mkb;
        @(posedge clk);
        #1;
        if (ratio != m_ratio || wa != m_wa_en || mkb != m_mkbit) begin
            modelClear();
            m_ratio = ratio; m_wa_en = wa; m_mkbit = mkb;
        end else if (we) begin
            modelWord(d);
        end
        checkOutput("wa_lock", wa_lock, m_st == 2);
        checkOutput("wa_state", wa_state, m_st);
`ifdef AIB_WA_ERRCNT_EN
        checkOutput("err_cnt", err_cnt, m_err);
`endif
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [95:0] t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic sendWord(input bit we, input bit mk);
        logic [DW-1:0] d = randWord();
        d[cur_mk] = mk;
        applyStimulus(we, d, cur_ratio, cur_wa, cur_mk);
    endtask

    task automatic sendGroup(input int n, input bit bad);
        int badpos = $urandom_range(0, n - 1);
        for (int p = 0; p < n; p++) sendWord(1'b1, (p == n - 1) ^ (bad && p == badpos));
    endtask

    // Monitor: every strobe must match the oldest expected group, and no strobe may be missing.
    always @(negedge clk) begin
        logic [OW-1:0] e;
        checkOutput("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (out_valid) checkOutput("out_data", out_data, e);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gcnt, n;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; r_ratio = '0; r_wa_en = 1'b0; r_mkbit = '0;
        m_ratio = '0; m_wa_en = 1'b0; m_mkbit = '0;
        modelClear();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst out_data", out_data, '0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst wa_lock", wa_lock, 0);
        checkOutput("rst wa_state", wa_state, 0);
`ifdef AIB_WA_ERRCNT_EN
        checkOutput("rst err_cnt", err_cnt, 0);
`endif
        rst_n = 1'b1;

        $display("[TB] 4x aligned stream, marker on bit 79");
        cur_ratio = 2'd2; cur_wa = 1'b1; cur_mk = 7'd79;
        sendWord(1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) sendWord(1'b1, (i % 4) == 0);

        $display("[TB] locked 4x: 3 bad, 1 good, 4 bad groups");
        for (int g = 0; g < 8; g++) sendGroup(4, g != 3);

        $display("[TB] 4x off-phase restart and slip");
        sendWord(1'b1, 1'b0);
        sendWord(1'b1, 1'b0);
        sendWord(1'b1, 1'b1);
        for (int g = 0; g < 3; g++) sendGroup(4, 1'b0);

        $display("[TB] ratio change to 2x mid-group");
        sendWord(1'b1, 1'b0);
        sendWord(1'b1, 1'b0);
        cur_ratio = 2'd1;
        sendWord(1'b1, 1'b0);
        for (int g = 0; g < 3; g++) sendGroup(2, 1'b0);

        $display("[TB] 2x gapped 1-of-3, marker on odd words");
        cur_mk = 7'd40;
        sendWord(1'b0, 1'b0);
        for (int w = 0; w < 6; w++) begin
            sendWord(1'b1, (w % 2) == 1);
            sendWord(1'b0, 1'b0);
            sendWord(1'b0, 1'b0);
        end

        $display("[TB] reset mid-group");
        sendWord(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        m_ratio = '0; m_wa_en = 1'b0; m_mkbit = '0;
        modelClear();
        exp_q.delete();
        checkOutput("midrst out_data", out_data, '0);
        checkOutput("midrst out_valid", out_valid, 0);
        checkOutput("midrst wa_lock", wa_lock, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] randomized stream");
        gcnt = 0;
        for (int c = 0; c < 500; c++) begin
            if (c == 0 || $urandom_range(0, 59) == 0) begin
                cur_ratio = 2'($urandom_range(0, 3));
                cur_wa    = ($urandom_range(0, 4) != 0);
                cur_mk    = 7'($urandom_range(0, DW - 1));
                gcnt = 0;
            end
            n = nOf(cur_ratio);
            if ($urandom_range(0, 4) != 0) begin
                sendWord(1'b1, ((gcnt % n) == n - 1) ^ ($urandom_range(0, 24) == 0));
                gcnt++;
            end else begin
                sendWord(1'b0, 1'b0);
            end
        end
        sendWord(1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
